ifu_fetch: RTL and testbench

- Instruction-fetch stage directly downstream of the PC register.
- Takes the current pc, issues one read to instruction memory over a valid/ready request/response handshake, and presents the instruction to decode with a valid/ready handshake.
- Drives the PC write-enable: one boot pulse after reset, then one pulse per retired instruction.
- The PC register resets to 0x7FFFFFFC and loads dnpc = pc+4 on its first enable, so the first fetch is at 0x80000000.

---
 rtl/ifu_fetch.sv | 120 ++++++++++++
 tb/tb_ifu_fetch.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch.sv
// Instruction-fetch stage: boots the PC register, issues one instruction read per
// retired instruction, and hands the fetched word to decode over valid/ready.
module ifu_fetch #(
    parameter int XLEN        = 32,
    parameter bit ALIGN_CHECK = 1'b1,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [XLEN-1:0]  pc_i,
    output logic             pc_wen,
    output logic             mem_arvalid,
    output logic [XLEN-1:0]  mem_araddr,
    input  logic             mem_arready,
    input  logic             mem_rvalid,
    input  logic [XLEN-1:0]  mem_rdata,
    input  logic [1:0]       mem_rresp,
    output logic             mem_rready,
    output logic             inst_valid,
    output logic [XLEN-1:0]  inst,
    output logic [XLEN-1:0]  inst_pc,
    output logic             inst_fault,
    input  logic             inst_ready,
    input  logic             commit,
    output logic [CNT_W-1:0] fetch_cnt
);

    typedef enum logic [2:0] {
        BOOT,
        REQ,
        RESP,
        OUT,
        WAIT_CMT,
        ADV
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [XLEN-1:0]  araddr_q;
    logic [XLEN-1:0]  inst_q;
    logic [XLEN-1:0]  inst_pc_q;
    logic             fault_q;
    logic [CNT_W-1:0] cnt_q;
    logic             misaligned;

    assign misaligned = ALIGN_CHECK && (pc_i[1:0] != 2'b00);

    always_comb begin
        // NOTE: default assigned first so every path drives state_nxt and no latch is inferred.
        state_nxt = state;
        unique case (state)
            BOOT:     state_nxt = REQ;
            REQ: begin
                if (misaligned)       state_nxt = OUT;
                else if (mem_arready) state_nxt = RESP;
            end
            RESP:     if (mem_rvalid) state_nxt = RESP == state ? OUT : state;
            OUT:      if (inst_ready) state_nxt = commit ? ADV : WAIT_CMT;
            WAIT_CMT: if (commit)     state_nxt = ADV;
            ADV:      state_nxt = REQ;
            default:  state_nxt = BOOT;
        endcase
    end

    // The PC register only moves on pc_wen, so pc_i is steady for the whole REQ
    // stay and can be presented directly; araddr_q keeps it for RESP.
    assign mem_araddr  = (state == REQ) ? pc_i : araddr_q;
    assign mem_arvalid = (state == REQ) && !misaligned;
    assign mem_rready  = (state == RESP);
    assign inst_valid  = (state == OUT);
    assign inst_fault  = inst_valid && fault_q;
    assign inst        = inst_q;
    assign inst_pc     = inst_pc_q;
    assign fetch_cnt   = cnt_q;
    // BOOT is also the reset state, so the boot pulse is held off while rst is high.
    assign pc_wen      = (state == ADV) || ((state == BOOT) && !rst);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= BOOT;
            araddr_q  <= '0;
            inst_q    <= '0;
            inst_pc_q <= '0;
            fault_q   <= 1'b0;
            cnt_q     <= '0;
        end else begin
            // NOTE: all registered state uses non-blocking assignments so every flop samples pre-edge values.
            state <= state_nxt;
            unique case (state)
                REQ: begin
                    araddr_q <= pc_i;
                    if (misaligned) begin
                        inst_q    <= '0;
                        inst_pc_q <= pc_i;
                        fault_q   <= 1'b1;
                    end
                end
                RESP: begin
                    if (mem_rvalid) begin
                        inst_q    <= mem_rdata;
                        inst_pc_q <= araddr_q;
                        fault_q   <= (mem_rresp != 2'b00);
                    end
                end
                OUT: begin
                    if (inst_ready) cnt_q <= cnt_q + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

`ifndef SYNTHESIS
    a_one_channel: assert property (@(posedge clk) disable iff (rst)
        !(mem_arvalid && mem_rready));
    a_pc_wen_pulse: assert property (@(posedge clk) disable iff (rst)
        pc_wen |=> !pc_wen);
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: PC register and memory models, a table of fetch
// scenarios, and hand-written reset / wrap sequences.
module tb_ifu_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_i;
    logic        pc_wen;
    logic        mem_arvalid;
    logic [31:0] mem_araddr;
    logic        mem_arready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic [1:0]  mem_rresp;
    logic        mem_rready;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_fault;
    logic        inst_ready;
    logic        commit;
    logic [31:0] fetch_cnt;

    logic        w_pc_wen;
    logic        w_arvalid;
    logic [31:0] w_araddr;
    logic        w_rready;
    logic        w_inst_valid;
    logic [31:0] w_inst;
    logic [31:0] w_inst_pc;
    logic        w_inst_fault;
    logic [1:0]  w_fetch_cnt;

    always #5 clk = ~clk;

    ifu_fetch #(.XLEN(32), .ALIGN_CHECK(1'b1), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .pc_i(pc_i), .pc_wen(pc_wen),
        .mem_arvalid(mem_arvalid), .mem_araddr(mem_araddr), .mem_arready(mem_arready),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_rresp(mem_rresp),
        .mem_rready(mem_rready), .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
        .inst_fault(inst_fault), .inst_ready(inst_ready), .commit(commit),
        .fetch_cnt(fetch_cnt)
    );

    // Narrow-counter twin fed the same inputs, used only for the wrap check.
    ifu_fetch #(.XLEN(32), .ALIGN_CHECK(1'b1), .CNT_W(2)) dut_w (
        .clk(clk), .rst(rst), .pc_i(pc_i), .pc_wen(w_pc_wen),
        .mem_arvalid(w_arvalid), .mem_araddr(w_araddr), .mem_arready(mem_arready),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_rresp(mem_rresp),
        .mem_rready(w_rready), .inst_valid(w_inst_valid), .inst(w_inst), .inst_pc(w_inst_pc),
        .inst_fault(w_inst_fault), .inst_ready(inst_ready), .commit(commit),
        .fetch_cnt(w_fetch_cnt)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // PC register model: resets to 0x7FFFFFFC, steps by 4 unless a jump is staged.
    logic        jump_en;
    logic [31:0] jump_pc;
    always @(posedge clk or posedge rst) begin
        if (rst)         pc_i <= 32'h7FFF_FFFC;
        else if (pc_wen) pc_i <= jump_en ? jump_pc : pc_i + 32'd4;
    end

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return (addr == 32'h8000_0000) ? 32'h0000_0413 : {addr[15:0], 16'h0093};
    endfunction

    // Memory model: arready after ar_stall waiting cycles, rvalid after r_delay.
    int          ar_stall, r_delay, ar_cnt, r_cnt;
    logic [1:0]  rresp_cfg;
    logic        force_rvalid;
    always @(negedge clk) begin
        if (mem_arvalid) begin
            mem_arready = (ar_cnt == ar_stall);
            ar_cnt++;
        end else begin
            mem_arready = 1'b0;
            ar_cnt = 0;
        end
        if (mem_rready) begin
            if (r_cnt == r_delay) begin
                mem_rvalid = 1'b1;
                mem_rdata  = mem_word(mem_araddr);
                mem_rresp  = rresp_cfg;
            end else begin
                mem_rvalid = 1'b0;
                mem_rdata  = 32'hDEAD_BEEF;
                mem_rresp  = 2'b11;
            end
            r_cnt++;
        end else begin
            mem_rvalid = force_rvalid;
            mem_rdata  = 32'hBAD0_0BAD;
            mem_rresp  = 2'b11;
            r_cnt = 0;
        end
    end

    // Protocol monitor: pc_wen pulses, request cycles, and rule violations.
    int   pcw_cnt, arv_cycles;
    int   viol = 0;
    logic pcw_prev;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pcw_cnt = 0;
            arv_cycles = 0;
            pcw_prev = 1'b0;
        end else begin
            if (pc_wen) pcw_cnt++;
            if (mem_arvalid) arv_cycles++;
            if (pc_wen && pcw_prev) viol++;
            if (mem_arvalid && mem_rready) viol++;
            pcw_prev = pc_wen;
        end
    end

    typedef struct {
        logic [31:0] pc;
        bit          jump;
        int          ar_stall;
        int          r_delay;
        int          rdy;
        logic [1:0]  rresp;
        bit          spur;
        bit          cmt_hs;
        int          lat;
        int          arv;
        logic [31:0] inst;
        bit          fault;
    } vec_t;

    localparam int NV = 6;
    vec_t vecs[NV];

    // Starts on the first REQ cycle; ends on the first REQ cycle of the next fetch.
    task automatic run_vec(input int i);
        vec_t v;
        int   n;
        int   arv0;
        bit   bad;
        v = vecs[i];
        ar_stall  = v.ar_stall;
        r_delay   = v.r_delay;
        rresp_cfg = v.rresp;
        jump_en   = 1'b0;
        arv0 = arv_cycles;
        n = 0;
        bad = 1'b0;
        while (!inst_valid && n < 40) begin
            if ((mem_arvalid || mem_rready) && mem_araddr !== v.pc) bad = 1'b1;
            commit = v.spur && (n == 5);
            @(posedge clk); #1;
            n++;
        end
        commit = 1'b0;
        check($sformatf("v%0d_latency", i), n, v.lat);
        check($sformatf("v%0d_araddr_stable", i), bad, 0);
        check($sformatf("v%0d_inst", i), inst, v.inst);
        check($sformatf("v%0d_inst_pc", i), inst_pc, v.pc);
        check($sformatf("v%0d_fault", i), inst_fault, v.fault);
        check($sformatf("v%0d_req_cycles", i), arv_cycles - arv0, v.arv);
        check($sformatf("v%0d_pc_wen_count", i), pcw_cnt, 1 + i);

        bad = 1'b0;
        for (int k = 0; k < v.rdy; k++) begin
            @(posedge clk); #1;
            if (!inst_valid || inst !== v.inst || inst_pc !== v.pc ||
                inst_fault !== v.fault || fetch_cnt !== 32'(i)) bad = 1'b1;
        end
        if (v.rdy > 0) check($sformatf("v%0d_backpressure_hold", i), bad, 0);
        check($sformatf("v%0d_cnt_before", i), fetch_cnt, i);

        inst_ready = 1'b1;
        commit     = v.cmt_hs;
        if (i + 1 < NV) begin
            jump_en = vecs[i + 1].jump;
            jump_pc = vecs[i + 1].pc;
        end
        @(posedge clk); #1;
        inst_ready = 1'b0;
        commit     = 1'b0;
        check($sformatf("v%0d_cnt_after", i), fetch_cnt, i + 1);
        check($sformatf("v%0d_valid_drop", i), inst_valid, 0);
        check($sformatf("v%0d_pc_wen_post_hs", i), pc_wen, v.cmt_hs);
        if (!v.cmt_hs) begin
            commit = 1'b1;
            @(posedge clk); #1;
            commit = 1'b0;
        end
        check($sformatf("v%0d_adv_pulse", i), pc_wen, 1);
        @(posedge clk); #1;
        check($sformatf("v%0d_adv_single", i), pc_wen, 0);
    endtask

    initial begin
        rst = 1'b1;
        mem_arready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; mem_rresp = '0;
        inst_ready = 1'b0; commit = 1'b0; jump_en = 1'b0; jump_pc = '0;
        ar_stall = 0; r_delay = 0; rresp_cfg = '0; force_rvalid = 1'b0;
        ar_cnt = 0; r_cnt = 0;

        vecs[0] = '{pc:32'h8000_0000, jump:0, ar_stall:0, r_delay:0, rdy:0, rresp:2'd0,
                    spur:0, cmt_hs:0, lat:2, arv:1, inst:32'h0000_0413, fault:0};
        vecs[1] = '{pc:32'h8000_0004, jump:0, ar_stall:3, r_delay:4, rdy:0, rresp:2'd0,
                    spur:1, cmt_hs:0, lat:9, arv:4, inst:32'h0004_0093, fault:0};
        vecs[2] = '{pc:32'h8000_0008, jump:0, ar_stall:0, r_delay:0, rdy:5, rresp:2'd0,
                    spur:0, cmt_hs:0, lat:2, arv:1, inst:32'h0008_0093, fault:0};
        vecs[3] = '{pc:32'h8000_000C, jump:0, ar_stall:0, r_delay:0, rdy:0, rresp:2'd2,
                    spur:0, cmt_hs:0, lat:2, arv:1, inst:32'h000C_0093, fault:1};
        vecs[4] = '{pc:32'h8000_0002, jump:1, ar_stall:0, r_delay:0, rdy:0, rresp:2'd0,
                    spur:0, cmt_hs:0, lat:1, arv:0, inst:32'h0000_0000, fault:1};
        vecs[5] = '{pc:32'h8000_0010, jump:1, ar_stall:1, r_delay:2, rdy:0, rresp:2'd0,
                    spur:0, cmt_hs:1, lat:5, arv:2, inst:32'h0010_0093, fault:0};

        repeat (3) @(posedge clk);
        #1;
        check("rst_pc_wen", pc_wen, 0);
        check("rst_arvalid", mem_arvalid, 0);
        check("rst_rready", mem_rready, 0);
        check("rst_inst_valid", inst_valid, 0);
        check("rst_inst_fault", inst_fault, 0);
        check("rst_inst", inst, 0);
        check("rst_inst_pc", inst_pc, 0);
        check("rst_araddr", mem_araddr, 0);
        check("rst_fetch_cnt", fetch_cnt, 0);

        @(negedge clk);
        rst = 1'b0;
        #1;
        check("boot_pulse", pc_wen, 1);
        @(posedge clk); #1;
        check("boot_single", pc_wen, 0);
        check("boot_pc", pc_i, 32'h8000_0000);

        for (int i = 0; i < NV; i++) run_vec(i);

        check("pc_wen_total", pcw_cnt, 1 + NV);
        check("cnt_wrap", w_fetch_cnt, 2);

        // Reset while waiting for read data, with a stray rvalid during and after reset.
        ar_stall = 0;
        r_delay  = 20;
        @(posedge clk); #1;
        check("mid_rready", mem_rready, 1);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        check("async_rready", mem_rready, 0);
        check("async_pc_wen", pc_wen, 0);
        check("async_inst_valid", inst_valid, 0);
        check("async_fetch_cnt", fetch_cnt, 0);
        check("async_araddr", mem_araddr, 0);
        force_rvalid = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reboot_pulse", pc_wen, 1);
        @(posedge clk); #1;
        force_rvalid = 1'b0;
        check("reboot_inst_valid", inst_valid, 0);
        check("reboot_pc", pc_i, 32'h8000_0000);
        run_vec(0);

        check("protocol_violations", viol, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
